// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding and one-hot helper for the scan decoder family
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } state_t;

   // Widest one-hot the helper can build; covers index widths up to 8 bits.
   localparam int ONEHOT_MAX_W = 256;

   // Callers cast the result down to their own 2**N width.
   function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned i);
      return ONEHOT_MAX_W'(1) << i;
   endfunction

endpackage

// File: rtl/scan_decoder_nbit_next_chan_search.sv
// next_chan_search: combinational round-robin finder of the next set mask bit strictly after cur
module next_chan_search #(
   parameter int N = 3
) (
   input  logic [2**N-1:0] mask,
   input  logic [N-1:0]    cur,
   output logic [N-1:0]    nxt,
   output logic            wrapped,
   output logic            found
);

   // walk from the farthest candidate to the nearest so the nearest set bit wins;
   // the farthest candidate (offset 2**N) is cur itself, so a lone channel finds itself
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      for (int i = 2**N; i >= 1; i--) begin
         if (mask[cur + N'(i)]) begin
            nxt   = cur + N'(i);
            found = 1'b1;
         end
      end
      wrapped = found && (nxt <= cur);
   end

endmodule

// File: rtl/scan_decoder_nbit.sv
// scan_decoder_nbit: registered N-to-2^N one-hot decoder with direct decode and masked scan modes
// Define SCAN_DECODER_BLANK_EN to insert a one-cycle blank (y=0) after every scan dwell expiry.
module scan_decoder_nbit
   import scan_decoder_pkg::*;
#(
   parameter int N       = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               mode,
   input  logic [N-1:0]       a,
   input  logic [2**N-1:0]    ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               load,
   input  logic [N-1:0]       load_idx,
   output logic [2**N-1:0]    y,
   output logic [N-1:0]       idx,
   output logic               wrap
);

   localparam int W = 2**N;

   state_t             state_q, state_d;
   logic [N-1:0]       idx_d, nxt;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]       y_d;
   logic               wrap_d, wrapped, found, expired;

   next_chan_search #(.N(N)) u_search (
      .mask    (ch_mask),
      .cur     (idx),
      .nxt     (nxt),
      .wrapped (wrapped),
      .found   (found)
   );

   // an established scan channel has used up its dwell and some channel is enabled
   assign expired = (state_q == SCAN) && found && (cnt_q >= dwell);

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // state follows enable/mode every cycle; with blanking an unloaded expiry detours through BLANK
   always_comb begin
      state_d = !enable ? IDLE : !mode ? DIRECT : SCAN;
`ifdef SCAN_DECODER_BLANK_EN
      if (state_d == SCAN && expired && !load) state_d = BLANK;
`endif
   end

   // next index, dwell count, wrap and select for the state being entered
   always_comb begin
      idx_d  = idx;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (state_d == DIRECT) begin
         idx_d = a;
         cnt_d = '0;
      end else if (state_d != IDLE) begin
         if (load) begin
            idx_d = load_idx;
            cnt_d = '0;
         end else if (expired) begin
            idx_d  = nxt;
            cnt_d  = '0;
            wrap_d = wrapped;
         end else if (state_q != SCAN || !found) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
      y_d = (state_d == DIRECT || state_d == SCAN) ? W'(onehot(32'(idx_d))) & ch_mask : '0;
   end

   // output and counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         y     <= '0;
         idx   <= '0;
         wrap  <= 1'b0;
         cnt_q <= '0;
      end else begin
         y     <= y_d;
         idx   <= idx_d;
         wrap  <= wrap_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/scan_decoder_nbit.md
Name: scan_decoder_nbit

Overview:
- Parametrised registered N-to-2^N one-hot decoder with a second, self-sequencing scan mode.
- Direct mode: registered decode of an input index.
- Scan mode: steps the one-hot select through every channel enabled in a mask, ascending, dwelling a programmable number of cycles per channel.
- Drives multiplexed channel selects (display digits, sensor rows); emits a frame-wrap pulse.

Parameters:
- N, 3, index width; output width 2**N.
- DWELL_W, 8, width of the dwell count input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- enable  input  1  1 = drive outputs; 0 = blank y and hold idx.
- mode  input  1  0 = direct decode, 1 = scan.
- a  input  N  direct-mode index.
- ch_mask  input  2**N  per-channel enable; y is always ANDed with it.
- dwell  input  DWELL_W  scan: channel held for dwell+1 cycles.
- load  input  1  scan: force idx to load_idx.
- load_idx  input  N  index applied on load.
- y  output  2**N  registered one-hot select.
- idx  output  N  registered current index.
- wrap  output  1  one-cycle pulse when the scan passes index 2**N-1 -> 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values: y=0, idx=0, wrap=0, dwell counter=0, state=IDLE.
- States:
  - IDLE when enable=0.
  - DIRECT when enable=1, mode=0.
  - SCAN when enable=1, mode=1.
  - BLANK exists only with the optional feature.
  - State is re-evaluated every cycle from enable and mode.
- IDLE:
  - y=0 next cycle, wrap=0, idx held, counter held.
  - enable=0 dominates load and mode.
- DIRECT:
  - Next cycle idx=a, y=onehot(a)&ch_mask; latency 1 cycle.
  - Counter cleared; wrap=0; load ignored.
- SCAN entry (from DIRECT or IDLE):
  - Starts at the held idx with the counter cleared.
- SCAN, per cycle:
  - If load=1: idx=load_idx, counter=0. Load has priority over advance.
  - Else if counter >= dwell: advance idx to the next set bit of ch_mask strictly after idx, searching ascending with wrap-around; counter=0.
  - Else: counter+1.
  - Lowering dwell below the current count advances on the next cycle.
  - dwell=0 advances every cycle.
- wrap:
  - Asserted for the cycle in which idx is updated by an advance whose search crossed 2**N-1 -> 0.
  - With a single enabled channel the advance lands on the same idx; wrap still pulses once per dwell period.
  - Never asserted on load.
- ch_mask=0 in SCAN: y=0, idx held, counter held at 0, wrap=0.
- Current channel masked mid-dwell: y goes 0 next cycle; the advance still happens at dwell expiry.
- y in SCAN: registered onehot(idx)&ch_mask, updated in the same cycle as idx.
- Reset mid-scan: all registers return to their reset values on that edge regardless of other inputs.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_EN.
- Defined:
  - At each dwell expiry in SCAN, enter BLANK for one cycle: y=0, idx already updated, wrap pulses in that cycle if applicable.
  - Then return to SCAN showing the new channel with counter=0.
  - Channel period = dwell+2 cycles.
  - load during BLANK is applied and exits BLANK.
- Undefined: no BLANK state; period = dwell+1 cycles.

Decomposition:
- Shared package scan_decoder_pkg:
  - state enum (IDLE, DIRECT, SCAN, BLANK);
  - onehot function parameterised on N.
- Sub-module next_chan_search: combinational round-robin next-set-bit finder.
  - Inputs: mask, current idx.
  - Outputs: next idx, wrapped flag, found flag.
  - Reusable by the team's planned arbiter.

Test Plan (N=3, macro undefined unless stated):
- Reset: reset_n=0 for 2 cycles with enable=1, mode=1 -> y=8'h00, idx=0, wrap=0; hold reset mid-scan at idx=5 -> idx=0 on the next edge.
- Direct: mask=8'hFF, mode=0, a=5 -> y=8'h20 one cycle later; a=0 -> 8'h01; mask=8'hFE with a=0 -> y=8'h00, idx=0.
- Scan: mask=8'hFF, dwell=2 -> idx sequence 0,0,0,1,1,1,...,7,7,7,0; wrap high exactly once per 24 cycles, on the 7->0 update.
- Sparse mask: mask=8'h82, dwell=0, start idx=1 -> idx alternates 1,7,1,7; y alternates 8'h02/8'h80; wrap pulses on each 7->1 update.
- Load and empty mask: load=1 with load_idx=4 mid-dwell -> idx=4, counter=0, no wrap next cycle; then mask=8'h00 -> y=8'h00, idx stays 4, no wrap.
- Enable drop and blank option:
  - enable=0 at idx=3 -> y=0 next cycle; re-enable with mode=1 -> resumes at idx=3 with a full dwell.
  - With SCAN_DECODER_BLANK_EN, dwell=1 -> y pattern ch,ch,0,ch',ch',0.
